spart_bus_intf: RTL and testbench
=================================

// Module: spart_bus_intf
// PURPOSE
//  Processor-side bus interface of the SPART, directly downstream of the bus driver.
//  Decodes iocs/iorw/ioaddr, drives and samples the shared tri-state databus, and holds the TX, RX,
//  status and divisor registers. Generates rda/tbr back to the driver.
//  Contains the baud-rate generator whose enable pulse paces the SPART TX/RX shift engines.
// PARAMETERS
//  DEFAULT_DIV  16'd325  divisor loaded into {db_hi,db_lo} at reset
//  CNT_W        16       baud counter / divisor width (DB registers are 2x8 bits; CNT_W must be 16)
// PORTS
//  clk        in     1  system clock
//  rst_n      in     1  asynchronous active-low reset
//  iocs       in     1  chip select; a bus access happens in every cycle it is high
//  iorw       in     1  1 = read (block drives databus), 0 = write (block samples databus)
//  ioaddr     in     2  00 TX/RX buffer, 01 status, 10 DB low, 11 DB high
//  databus    inout  8  shared bidirectional data bus
//  rda        out    1  receive data available
//  tbr        out    1  transmit buffer ready
//  tx_data    out    8  byte handed to TX engine
//  tx_load    out    1  one-cycle pulse: TX engine takes tx_data
//  tx_busy    in     1  TX engine shifting; cannot accept tx_load
//  rx_data    in     8  byte from RX engine, valid with rx_valid
//  rx_valid   in     1  one-cycle pulse: new received byte
//  baud_en    out    1  one-cycle pulse every (divisor+1) clocks
// BEHAVIOUR
//  Reset: rda=0, tbr=1, tx_load=0, tx_data=0, baud_en=0, rx_buf=0, ovr flags=0,
//    DB=DEFAULT_DIV, counter=DEFAULT_DIV, databus released (Z).
//  Bus read: databus driven combinationally only when iocs&&iorw&&ioaddr in {00,01}; Z otherwise.
//    Read data is available in the same cycle as iocs (zero latency); the driver samples it at that clock edge.
//    00 -> rx_buf; 01 -> {4'b0, tx_ovr, rx_ovr, rda, tbr}; reads of 10/11 leave the bus Z.
//  Bus write: captured at the posedge where iocs&&!iorw.
//    00: if tbr, then tx_buf<=databus and tx_pend<=1; else drop the byte and set tx_ovr.
//    10/11: write db_lo/db_hi. 01: ignored.
//  TX handshake: when tx_pend && !tx_busy, tx_load pulses 1 cycle with tx_data=tx_buf, then tx_pend<=0.
//    tbr = !tx_pend && !tx_busy (combinational).
//  RX: rx_valid -> rx_buf<=rx_data, rda<=1. If rda already 1 and no read of 00 in that cycle, set rx_ovr (overwrite).
//    A read of 00 clears rda at the next edge.
//    rx_valid coincident with a read of 00: the read returns the old byte; the new byte is stored; rda stays 1; no ovr.
//  Reading status clears tx_ovr and rx_ovr at the next edge. A set event in the same cycle wins (flag stays 1).
//  Baud gen: 16-bit down counter.
//    When counter==0: baud_en=1 for that cycle and counter<={db_hi,db_lo}; otherwise decrement.
//    A write to 10 or 11 forces a reload with the new divisor at the next edge; no baud_en on the reload cycle.
//    Divisor==0: baud_en held 0 and counter held 0 (generator disabled).
//  Reset mid-operation: async return to reset values. Any pending TX byte or unread RX byte is discarded.
// STRUCTURE
//  spart_pkg:
//    - ioaddr_t enum: ADDR_BUF=2'b00, ADDR_STATUS=2'b01, ADDR_DB_LO=2'b10, ADDR_DB_HI=2'b11.
//    - Status bit index constants: ST_TBR=0, ST_RDA=1, ST_RXOVR=2, ST_TXOVR=3.
//    - DEFAULT_DIV constant.
//  Sub-module spart_baud_gen: clk, rst_n, divisor[15:0], reload, baud_en. Holds the counter.
//  This block keeps the bus decode, the registers and the tri-state driver.
// TESTING
//  1. Reset with DEFAULT_DIV=325 -> tbr=1, rda=0, databus Z; baud_en first pulses 326 clocks after reset, then every 326.
//  2. Write 10<-8'h04, 11<-8'h00 -> after the reload, baud_en pulses every 5 clocks; write 0 to both -> baud_en stays 0.
//  3. Write 00<-8'hA5 with tx_busy=0 -> next cycle tx_load=1 with tx_data=A5, tbr low while pending;
//       2nd write while tx_busy=1 -> byte dropped, status read = 8'h08.
//  4. rx_valid with rx_data=8'h3C -> rda=1; read 00 returns 3C in the same cycle; rda=0 next cycle.
//  5. Two rx_valid (11 then 22) with no read -> read 00 returns 22, status bit2=1; a second status read shows bit2=0.
//  6. rx_valid(8'h77) in the same cycle as a read of 00 holding 8'h11 -> bus=11, rda stays 1, next read=77, rx_ovr=0;
//       assert rst_n low mid-transfer -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART processor-side bus interface:
// register addresses, status bit positions and the reset baud divisor.
package spart_pkg;

  typedef enum logic [1:0] {
    ADDR_BUF    = 2'b00,
    ADDR_STATUS = 2'b01,
    ADDR_DB_LO  = 2'b10,
    ADDR_DB_HI  = 2'b11
  } ioaddr_t;

  localparam int unsigned ST_TBR   = 0;
  localparam int unsigned ST_RDA   = 1;
  localparam int unsigned ST_RXOVR = 2;
  localparam int unsigned ST_TXOVR = 3;

  localparam logic [15:0] DEFAULT_DIV = 16'd325;

endpackage

// File: rtl/spart_bus_intf_if.sv
// Control side of the SPART processor bus: chip select, direction, address, rda/tbr.
// The shared tri-state databus stays a module-level inout so it resolves at the pins.
interface spart_bus_intf_if;

  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);

endinterface

// File: rtl/spart_baud_gen.sv
// Baud-rate generator: down counter emitting a one-cycle enable every (divisor+1) clocks.
// A divisor of zero parks the counter at zero and disables the enable.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter int unsigned      CNT_W     = 16,
  parameter logic [CNT_W-1:0] RESET_DIV = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] divisor,
  input  logic             reload,
  output logic             baud_en
);

  logic [CNT_W-1:0] cnt;

  assign baud_en = !reload && (divisor != '0) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RESET_DIV;
    end else if (reload) begin
      cnt <= divisor;
    end else if (divisor == '0) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= divisor;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/spart_bus_intf.sv
// SPART bus interface: address decode, tri-state databus, TX/RX/status/divisor
// registers, TX/RX engine handshake and the baud generator instance.
module spart_bus_intf
  import spart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spart_bus_intf_if.slave      bus,
  inout  wire  [7:0]           databus,
  output logic [7:0]           tx_data,
  output logic                 tx_load,
  input  logic                 tx_busy,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 baud_en
);

  ioaddr_t          addr;
  logic             rd_buf, rd_st, wr_buf, wr_lo, wr_hi;
  logic [7:0]       tx_buf, rx_buf, db_lo, db_hi;
  logic             tx_pend, rda, tx_ovr, rx_ovr, tbr;
  logic [7:0]       status, rd_data;
  logic [CNT_W-1:0] div_next;

  assign addr   = ioaddr_t'(bus.ioaddr);
  assign rd_buf = bus.iocs &&  bus.iorw && (addr == ADDR_BUF);
  assign rd_st  = bus.iocs &&  bus.iorw && (addr == ADDR_STATUS);
  assign wr_buf = bus.iocs && !bus.iorw && (addr == ADDR_BUF);
  assign wr_lo  = bus.iocs && !bus.iorw && (addr == ADDR_DB_LO);
  assign wr_hi  = bus.iocs && !bus.iorw && (addr == ADDR_DB_HI);

  assign tbr     = !tx_pend && !tx_busy;
  assign tx_load = tx_pend && !tx_busy;
  assign tx_data = tx_buf;
  assign bus.tbr = tbr;
  assign bus.rda = rda;

  always_comb begin
    status           = '0;
    status[ST_TBR]   = tbr;
    status[ST_RDA]   = rda;
    status[ST_RXOVR] = rx_ovr;
    status[ST_TXOVR] = tx_ovr;
  end

  assign rd_data = (addr == ADDR_BUF) ? rx_buf : status;
  assign databus = (rd_buf || rd_st) ? rd_data : 'z;

  // The generator reloads at the write edge itself, so it needs the divisor
  // as it will be after this cycle's write rather than the registered one.
  always_comb begin
    div_next = {db_hi, db_lo};
    if (wr_lo) div_next[7:0]  = databus;
    if (wr_hi) div_next[15:8] = databus;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf  <= '0;
      tx_pend <= 1'b0;
      rx_buf  <= '0;
      rda     <= 1'b0;
      tx_ovr  <= 1'b0;
      rx_ovr  <= 1'b0;
      db_lo   <= DEFAULT_DIV[7:0];
      db_hi   <= DEFAULT_DIV[15:8];
    end else begin
      if (tx_load) tx_pend <= 1'b0;
      if (wr_buf && tbr) begin
        tx_buf  <= databus;
        tx_pend <= 1'b1;
      end
      if (wr_lo) db_lo <= databus;
      if (wr_hi) db_hi <= databus;
      if (rx_valid) begin
        rx_buf <= rx_data;
        rda    <= 1'b1;
      end else if (rd_buf) begin
        rda <= 1'b0;
      end
      // Set events take priority over the clear-on-status-read.
      tx_ovr <= (wr_buf && !tbr) || (tx_ovr && !rd_st);
      rx_ovr <= (rx_valid && rda && !rd_buf) || (rx_ovr && !rd_st);
    end
  end

  spart_baud_gen #(
    .CNT_W     (CNT_W),
    .RESET_DIV (DEFAULT_DIV)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .divisor (div_next),
    .reload  (wr_lo || wr_hi),
    .baud_en (baud_en)
  );

endmodule

// File: tb/tb_spart_bus_intf.sv
// Self-checking bench for spart_bus_intf: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_spart_bus_intf;
  import spart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spart_bus_intf_if bus_if();

  wire  [7:0] databus;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_dout = '0;
  assign databus = tb_oe ? tb_dout : 'z;

  logic [7:0] tx_data, rx_data;
  logic       tx_load, tx_busy, rx_valid, baud_en;

  spart_bus_intf #(
    .DEFAULT_DIV (16'd325),
    .CNT_W       (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if.slave),
    .databus  (databus),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .baud_en  (baud_en)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: TX queue of accepted bytes, last RX byte, flags,
  // divisor bytes and edges elapsed since the last divisor load.
  logic [7:0]  m_txq[$];
  logic [7:0]  m_tx_last, m_rx, m_lo, m_hi;
  bit          m_rda, m_rxovr, m_txovr;
  int unsigned m_n;
  bit          m_rd0, m_rd1, m_wr0, m_wrlo, m_wrhi, m_tbr_pre, m_set_tx, m_set_rx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_txq.delete();
      m_tx_last = '0; m_rx = '0;
      m_rda = 0; m_rxovr = 0; m_txovr = 0;
      m_lo = 8'h45; m_hi = 8'h01;
      m_n = 0;
    end else begin
      m_rd0  = bus_if.iocs &&  bus_if.iorw && (bus_if.ioaddr == 2'd0);
      m_rd1  = bus_if.iocs &&  bus_if.iorw && (bus_if.ioaddr == 2'd1);
      m_wr0  = bus_if.iocs && !bus_if.iorw && (bus_if.ioaddr == 2'd0);
      m_wrlo = bus_if.iocs && !bus_if.iorw && (bus_if.ioaddr == 2'd2);
      m_wrhi = bus_if.iocs && !bus_if.iorw && (bus_if.ioaddr == 2'd3);
      m_tbr_pre = (m_txq.size() == 0) && !tx_busy;
      if (m_txq.size() != 0 && !tx_busy) void'(m_txq.pop_front());
      m_set_tx = m_wr0 && !m_tbr_pre;
      if (m_wr0 && m_tbr_pre) begin
        m_txq.push_back(tb_dout);
        m_tx_last = tb_dout;
      end
      m_set_rx = rx_valid && m_rda && !m_rd0;
      if (rx_valid) begin
        m_rx  = rx_data;
        m_rda = 1;
      end else if (m_rd0) begin
        m_rda = 0;
      end
      m_txovr = m_set_tx || (m_txovr && !m_rd1);
      m_rxovr = m_set_rx || (m_rxovr && !m_rd1);
      if (m_wrlo) m_lo = tb_dout;
      if (m_wrhi) m_hi = tb_dout;
      m_n = (m_wrlo || m_wrhi) ? 0 : m_n + 1;
    end
  end

  function automatic bit exp_baud();
    int unsigned d = {16'd0, m_hi, m_lo};
    bit db_wr = bus_if.iocs && !bus_if.iorw && bus_if.ioaddr[1];
    return (d != 0) && !db_wr && ((m_n % (d + 1)) == d);
  endfunction

  always @(negedge clk) begin
    bit e_tbr;
    e_tbr = (m_txq.size() == 0) && !tx_busy;
    check("tbr",     32'(bus_if.tbr), 32'(e_tbr));
    check("rda",     32'(bus_if.rda), 32'(m_rda));
    check("tx_load", 32'(tx_load),    32'((m_txq.size() != 0) && !tx_busy));
    check("tx_data", 32'(tx_data),    32'(m_tx_last));
    check("baud_en", 32'(baud_en),    32'(exp_baud()));
    if (rst_n && bus_if.iocs && bus_if.iorw && bus_if.ioaddr == 2'd0)
      check("rd_buf", 32'(databus), 32'(m_rx));
    if (rst_n && bus_if.iocs && bus_if.iorw && bus_if.ioaddr == 2'd1)
      check("rd_status", 32'(databus), {28'd0, m_txovr, m_rxovr, m_rda, e_tbr});
  end

  // Called at posedge+1; drives one cycle, samples the bus at the negedge.
  task automatic bus_cycle(input logic cs, input logic rw, input logic [1:0] a,
                           input logic [7:0] wd, input logic rxv, input logic [7:0] rxd,
                           output logic [7:0] rd);
    bus_if.iocs = cs; bus_if.iorw = rw; bus_if.ioaddr = a;
    tb_oe = cs && !rw; tb_dout = wd;
    rx_valid = rxv; rx_data = rxd;
    @(negedge clk);
    rd = databus;
    @(posedge clk); #1;
    bus_if.iocs = 1'b0; tb_oe = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic wait_baud(output int cyc);
    bit found = 0;
    cyc = 0;
    for (int i = 1; i <= 1000; i++) begin
      if (!found) begin
        @(negedge clk);
        if (baud_en) begin
          found = 1;
          cyc = i;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    int cyc;
    int pulses;
    bus_if.iocs = 0; bus_if.iorw = 0; bus_if.ioaddr = 0;
    tx_busy = 0; rx_valid = 0; rx_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tbr",     32'(bus_if.tbr), 32'd1);
    check("rst_rda",     32'(bus_if.rda), 32'd0);
    check("rst_tx_load", 32'(tx_load),    32'd0);
    check("rst_baud",    32'(baud_en),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Default divisor 325: pulse in the 326th cycle, then every 326
    wait_baud(cyc); check("baud_first_326", 32'(cyc), 32'd326);
    wait_baud(cyc); check("baud_period_326", 32'(cyc), 32'd326);

    bus_cycle(1, 0, 2'd2, 8'h04, 0, 8'h00, d);
    bus_cycle(1, 0, 2'd3, 8'h00, 0, 8'h00, d);
    wait_baud(cyc); check("baud_first_5", 32'(cyc), 32'd5);
    wait_baud(cyc); check("baud_period_5", 32'(cyc), 32'd5);
    bus_cycle(1, 0, 2'd2, 8'h00, 0, 8'h00, d);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (baud_en) pulses++;
      @(posedge clk); #1;
    end
    check("baud_disabled", 32'(pulses), 32'd0);
    bus_cycle(1, 0, 2'd2, 8'h02, 0, 8'h00, d);

    // TX accept, handshake and overrun
    bus_cycle(1, 0, 2'd0, 8'hA5, 0, 8'h00, d);
    @(negedge clk);
    check("tx_load_pulse", 32'(tx_load),    32'd1);
    check("tx_data_a5",    32'(tx_data),    32'hA5);
    check("tbr_pending",   32'(bus_if.tbr), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("tx_load_done",  32'(tx_load),    32'd0);
    check("tbr_back",      32'(bus_if.tbr), 32'd1);
    @(posedge clk); #1;
    tx_busy = 1;
    bus_cycle(1, 0, 2'd0, 8'h5A, 0, 8'h00, d);
    bus_cycle(1, 1, 2'd1, 8'h00, 0, 8'h00, d); check("status_txovr", 32'(d), 32'h08);
    bus_cycle(1, 1, 2'd1, 8'h00, 0, 8'h00, d); check("status_cleared", 32'(d), 32'h00);
    tx_busy = 0;
    @(negedge clk); check("tx_data_kept", 32'(tx_data), 32'hA5);
    @(posedge clk); #1;

    // RX single byte
    bus_cycle(0, 0, 2'd0, 8'h00, 1, 8'h3C, d);
    @(negedge clk); check("rda_set", 32'(bus_if.rda), 32'd1);
    @(posedge clk); #1;
    bus_cycle(1, 1, 2'd0, 8'h00, 0, 8'h00, d); check("rx_3c", 32'(d), 32'h3C);
    @(negedge clk); check("rda_clr", 32'(bus_if.rda), 32'd0);
    @(posedge clk); #1;

    // RX overrun
    bus_cycle(0, 0, 2'd0, 8'h00, 1, 8'h11, d);
    bus_cycle(0, 0, 2'd0, 8'h00, 1, 8'h22, d);
    bus_cycle(1, 1, 2'd0, 8'h00, 0, 8'h00, d); check("rx_22", 32'(d), 32'h22);
    bus_cycle(1, 1, 2'd1, 8'h00, 0, 8'h00, d); check("status_rxovr", 32'(d), 32'h05);
    bus_cycle(1, 1, 2'd1, 8'h00, 0, 8'h00, d); check("status_rxovr_clr", 32'(d), 32'h01);

    // rx_valid coincident with a buffer read
    bus_cycle(0, 0, 2'd0, 8'h00, 1, 8'h11, d);
    bus_cycle(1, 1, 2'd0, 8'h00, 1, 8'h77, d); check("rx_old_11", 32'(d), 32'h11);
    @(negedge clk); check("rda_kept", 32'(bus_if.rda), 32'd1);
    @(posedge clk); #1;
    bus_cycle(1, 1, 2'd1, 8'h00, 0, 8'h00, d); check("status_no_ovr", 32'(d), 32'h03);
    bus_cycle(1, 1, 2'd0, 8'h00, 0, 8'h00, d); check("rx_77", 32'(d), 32'h77);

    // Asynchronous reset with a pending TX byte and an unread RX byte
    bus_cycle(1, 0, 2'd0, 8'hC3, 0, 8'h00, d);
    tx_busy = 1;
    bus_cycle(0, 0, 2'd0, 8'h00, 1, 8'h5E, d);
    @(negedge clk);
    check("pre_rst_tbr",  32'(bus_if.tbr), 32'd0);
    check("pre_rst_rda",  32'(bus_if.rda), 32'd1);
    check("pre_rst_data", 32'(tx_data),    32'hC3);
    #2;
    rst_n = 1'b0;
    tx_busy = 0;
    #1;
    check("arst_tbr",     32'(bus_if.tbr), 32'd1);
    check("arst_rda",     32'(bus_if.rda), 32'd0);
    check("arst_tx_load", 32'(tx_load),    32'd0);
    check("arst_tx_data", 32'(tx_data),    32'h00);
    check("arst_baud",    32'(baud_en),    32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus_cycle(1, 1, 2'd0, 8'h00, 0, 8'h00, d); check("arst_rx_buf", 32'(d), 32'h00);
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
